// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the MIPS EX stage.
// Operations are accepted only while idle and commit to HI/LO after a fixed latency.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   counter;
    logic [31:0]     op_a, op_b;
    logic            op_signed;

    logic            is_mul_op, is_div_op;
    logic            capture, finish, write_hi, write_lo;

    logic [63:0]     a_ext, b_ext, product;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, q_mag, r_mag, quotient, remainder;

    assign is_mul_op = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
    assign is_div_op = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && is_mul_op)      state_next = MULT;
                else if (start && is_div_op) state_next = DIV;
            end
            MULT, DIV: begin
                if (counter == CW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: requests are honoured only in IDLE, completion when the counter runs out
    always_comb begin
        capture  = 1'b0;
        finish   = 1'b0;
        write_hi = 1'b0;
        write_lo = 1'b0;
        if (state == IDLE) begin
            capture  = start && (is_mul_op || is_div_op);
            write_hi = start && (mdOp == OP_MTHI);
            write_lo = start && (mdOp == OP_MTLO);
        end else begin
            finish   = (counter == CW'(1));
        end
    end

    // Signed division works on magnitudes; 0x80000000 / -1 then falls out as 0x80000000 rem 0.
    always_comb begin
        a_ext     = op_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
        b_ext     = op_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
        product   = a_ext * b_ext;
        a_neg     = op_signed && op_a[31];
        b_neg     = op_signed && op_b[31];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quotient  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        remainder = a_neg ? -r_mag : r_mag;
    end

    // NOTE: operand latches carry no reset; they are only read after a capture has loaded them.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_a      <= dataA;
            op_b      <= dataB;
            op_signed <= (mdOp == OP_MULT) || (mdOp == OP_DIV);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= finish;
            if (capture)
                counter <= is_mul_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            else if (state != IDLE)
                counter <= counter - CW'(1);
            if (write_hi) hi <= dataA;
            if (write_lo) lo <= dataA;
            if (finish) begin
                if (state == MULT) begin
                    hi <= product[63:32];
                    lo <= product[31:0];
                end else if (op_b != 32'b0) begin
                    hi <= remainder;
                    lo <= quotient;
                end
            end
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS datapath.
- Sits beside the ALU in the EX stage and owns the architectural HI/LO registers.
- Accepts an operation from the controller through a start handshake and asserts busy while computing, so the hazard unit can stall mfhi/mflo/md instructions.
- Commits the result to HI/LO after a fixed latency.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge clears state).
- start  input  1  request; sampled only when busy==0.
- mdOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
- dataA  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- dataB  input  32  rt operand (divisor / multiplier).
- busy  output  1  registered; 1 while an operation is in flight.
- done  output  1  registered; one-cycle pulse in the cycle HI/LO first shows a new mult/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: when reset==0 at an edge, busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0. This aborts any in-flight operation, and the result is discarded.
- States: IDLE, MULT, DIV.
- IDLE with start=1 and mdOp in {mult, multu}:
  - Capture dataA/dataB and the signedness.
  - Go to MULT and load counter = MULT_CYCLES.
  - busy=1 from the next cycle.
- IDLE with start=1 and mdOp in {div, divu}: same as above, but go to DIV with counter = DIV_CYCLES.
- IDLE with start=1 and mdOp=mthi: hi<=dataA at that edge, busy stays 0, no done.
- IDLE with start=1 and mdOp=mtlo: lo<=dataA at that edge, busy stays 0, no done.
- IDLE with start=1 and undefined mdOp: no state change.
- MULT/DIV: counter decrements each edge. On the edge where the counter reaches 0:
  - hi/lo are written.
  - busy<=0, done<=1 for exactly one cycle.
  - Return to IDLE.
  - Net timing: if start is sampled at edge E0, busy is high for exactly N cycles and hi/lo update at edge E0+N.
- start while busy=1: ignored entirely, including mthi/mtlo. The operands in flight are the ones captured at E0; later dataA/dataB changes have no effect.
- start in the cycle busy falls (busy==0 at sampling edge): accepted normally, so back-to-back operations are possible with zero idle cycles.
- Multiply result: {hi,lo} = 64-bit product. mult treats operands as two's complement; multu treats them as unsigned.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - divu is unsigned.
- Divisor==0: operation still runs DIV_CYCLES with busy and done as normal, but hi/lo are left unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- hi/lo change only at reset, mthi/mtlo, or completion; they hold their value during busy.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles with arbitrary inputs -> hi=0, lo=0, busy=0, done=0. Then start mult 3×4, and assert reset=0 at busy cycle 2 -> busy=0 next cycle, hi=lo=0, and no done ever pulses.
- Signed mult: dataA=0xFFFFFFFE (−2), dataB=0x00000003 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done high 1 cycle.
- Unsigned mult: multu, dataA=dataB=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- Signed div:
  - div −7/2 (0xFFFFFFF9, 0x00000002) -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then divu 0xFFFFFFF9/2 issued in the cycle busy falls -> accepted; after 10 more cycles lo=0x7FFFFFFC, hi=0x00000001.
- Divide edge cases:
  - Preload mthi 0x1234, mtlo 0x5678, then div by 0 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged, done pulses.
  - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy protection: start mult 6×7, then during busy issue mtlo 0xDEAD and change dataA/dataB every cycle -> the mtlo is ignored; final hi=0, lo=42 (0x2A). A following mtlo 0xBEEF in idle updates lo the next cycle with busy staying 0.
